fetch_buffer: RTL and testbench

- Parametrised instruction buffer between the fetch stage and decode in the superscalar RV32 pipeline.
- Accepts one FETCH_WIDTH-wide instruction bundle per cycle from instruction memory, tagging each instruction with its PC.
- Delivers up to DECODE_WIDTH oldest instructions per cycle, in program order, to decode.
- Supports a decode stall and a full flush (kill) for redirects, decoupling fetch bandwidth from decode bandwidth.

---
 rtl/fetch_buffer.sv | 140 ++++++++++++++
 tb/tb_fetch_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction buffer between fetch and decode.
//
// Takes one FETCH_WIDTH-wide bundle per cycle. The valid slots
// in_ofs .. in_ofs+in_cnt-1 are compacted and written in program order, and
// each entry is tagged with its own PC. Up to DECODE_WIDTH of the oldest
// entries are presented to decode every cycle.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   in_valid / in_ready fetch handshake. in_ready depends only on occupancy.
//   in_insn             bundle; slot i is at [i*INSN_LEN +: INSN_LEN]
//   in_pc               PC of slot 0; slot i has PC in_pc + 4*i
//   in_ofs, in_cnt      first valid slot and number of valid slots
//   out_insn, out_pc    oldest entries; lane 0 is the oldest
//   out_cnt             number of valid lanes, min(occupancy, DECODE_WIDTH)
//   deq_cnt, stall      lanes consumed this cycle (clamped to out_cnt);
//                       stall blocks the dequeue
//   kill                empties the buffer; takes priority over everything
//   occupancy           current entry count
//
// DEPTH must be a power of two and at least FETCH_WIDTH+DECODE_WIDTH.
// FETCH_WIDTH must be at least 2.
module fetch_buffer #(
    parameter int FETCH_WIDTH  = 4,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = 16,
    parameter int INSN_LEN     = 32,
    parameter int ADDR_LEN     = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [FETCH_WIDTH*INSN_LEN-1:0]  in_insn,
    input  logic [ADDR_LEN-1:0]              in_pc,
    input  logic [$clog2(FETCH_WIDTH)-1:0]   in_ofs,
    input  logic [$clog2(FETCH_WIDTH):0]     in_cnt,
    output logic [DECODE_WIDTH*INSN_LEN-1:0] out_insn,
    output logic [DECODE_WIDTH*ADDR_LEN-1:0] out_pc,
    output logic [$clog2(DECODE_WIDTH):0]    out_cnt,
    input  logic [$clog2(DECODE_WIDTH):0]    deq_cnt,
    input  logic                             stall,
    input  logic                             kill,
    output logic [$clog2(DEPTH):0]           occupancy
);

    localparam int OFS_W  = $clog2(FETCH_WIDTH);
    localparam int CNT_W  = OFS_W + 1;
    localparam int OCNT_W = $clog2(DECODE_WIDTH) + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    logic [INSN_LEN-1:0] mem_insn [DEPTH];
    logic [ADDR_LEN-1:0] mem_pc   [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [OCC_W-1:0]    occ;

    // Compacted view of the incoming bundle: entry j comes from slot in_ofs+j.
    logic [OFS_W-1:0]    slot_idx [FETCH_WIDTH];
    logic [INSN_LEN-1:0] cmp_insn [FETCH_WIDTH];
    logic [ADDR_LEN-1:0] cmp_pc   [FETCH_WIDTH];
    logic [PTR_W-1:0]    rd_idx   [DECODE_WIDTH];

    logic                enq_fire;
    logic [CNT_W-1:0]    enq_n;
    logic [OCNT_W-1:0]   deq_n;

    assign occupancy = occ;

    // Only the current count is used, so a decode dequeue in the same cycle
    // never feeds back into the fetch handshake.
    assign in_ready = (occ <= OCC_W'(DEPTH - FETCH_WIDTH));

    assign out_cnt  = (occ < OCC_W'(DECODE_WIDTH)) ? OCNT_W'(occ)
                                                   : OCNT_W'(DECODE_WIDTH);

    assign enq_fire = in_valid && in_ready && !kill;
    assign enq_n    = enq_fire ? in_cnt : '0;
    assign deq_n    = stall ? '0 : ((deq_cnt < out_cnt) ? deq_cnt : out_cnt);

    // NOTE: every always_comb output gets a default before any conditional
    // logic so no path can leave it unassigned and infer a latch.
    always_comb begin
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            slot_idx[j] = '0;
            cmp_insn[j] = '0;
            cmp_pc[j]   = '0;
        end
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            // Wraps mod FETCH_WIDTH; only entries j < in_cnt are ever
            // written, and for those in_ofs+j never wraps.
            slot_idx[j] = in_ofs + OFS_W'(j);
            cmp_insn[j] = in_insn[slot_idx[j]*INSN_LEN +: INSN_LEN];
            cmp_pc[j]   = in_pc + (ADDR_LEN'(slot_idx[j]) << 2);
        end
    end

    // Read ports: lanes at head+k, wrapping naturally with the pointer width.
    always_comb begin
        out_insn = '0;
        out_pc   = '0;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            rd_idx[k] = head + PTR_W'(k);
            out_insn[k*INSN_LEN +: INSN_LEN] = mem_insn[rd_idx[k]];
            out_pc[k*ADDR_LEN +: ADDR_LEN]   = mem_pc[rd_idx[k]];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            // NOTE: the storage array is reset as well, because outputs must
            // read zero straight out of reset; kill deliberately leaves it.
            for (int i = 0; i < DEPTH; i++) begin
                mem_insn[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else if (kill) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (enq_fire && (CNT_W'(j) < in_cnt)) begin
                    mem_insn[tail + PTR_W'(j)] <= cmp_insn[j];
                    mem_pc[tail + PTR_W'(j)]   <= cmp_pc[j];
                end
            end
            tail <= tail + PTR_W'(enq_n);
            head <= head + PTR_W'(deq_n);
            occ  <= occ + OCC_W'(enq_n) - OCC_W'(deq_n);
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_fetch_buffer;

    localparam int FW    = 4;
    localparam int DW    = 2;
    localparam int DEPTH = 16;
    localparam int IL    = 32;
    localparam int AL    = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [FW*IL-1:0] in_insn;
    logic [AL-1:0]    in_pc;
    logic [1:0]       in_ofs;
    logic [2:0]       in_cnt;
    logic [DW*IL-1:0] out_insn;
    logic [DW*AL-1:0] out_pc;
    logic [1:0]       out_cnt;
    logic [1:0]       deq_cnt;
    logic             stall;
    logic             kill;
    logic [4:0]       occupancy;

    fetch_buffer #(
        .FETCH_WIDTH (FW),
        .DECODE_WIDTH(DW),
        .DEPTH       (DEPTH),
        .INSN_LEN    (IL),
        .ADDR_LEN    (AL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_insn  (in_insn),
        .in_pc    (in_pc),
        .in_ofs   (in_ofs),
        .in_cnt   (in_cnt),
        .out_insn (out_insn),
        .out_pc   (out_pc),
        .out_cnt  (out_cnt),
        .deq_cnt  (deq_cnt),
        .stall    (stall),
        .kill     (kill),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IL-1:0] insn;
        logic [AL-1:0] pc;
    } entry_t;

    entry_t q[$];   // reference model: program-order FIFO contents
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, expv, $time);
        end
    endtask

    // Compare outputs with the model, then advance the model and the DUT by
    // one clock edge using the inputs currently driven.
    task automatic cycle();
        int sz, on, dn;
        bit accept;
        entry_t e;
        #1;
        sz = q.size();
        on = (sz < DW) ? sz : DW;
        check("occupancy", 64'(occupancy), 64'(sz));
        check("in_ready", 64'(in_ready), 64'((DEPTH - sz) >= FW));
        check("out_cnt", 64'(out_cnt), 64'(on));
        for (int k = 0; k < on; k++) begin
            check($sformatf("lane%0d_insn", k), 64'(out_insn[k*IL +: IL]), 64'(q[k].insn));
            check($sformatf("lane%0d_pc", k), 64'(out_pc[k*AL +: AL]), 64'(q[k].pc));
        end
        if (kill) begin
            q.delete();
        end else begin
            dn = stall ? 0 : ((int'(deq_cnt) < on) ? int'(deq_cnt) : on);
            accept = in_valid && ((DEPTH - sz) >= FW);
            repeat (dn) void'(q.pop_front());
            if (accept) begin
                for (int j = 0; j < int'(in_cnt); j++) begin
                    int s;
                    s = int'(in_ofs) + j;
                    e.insn = in_insn[s*IL +: IL];
                    e.pc   = in_pc + AL'(4 * s);
                    q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [AL-1:0] pc, input int ofs, input int cnt,
                         input int deq, input bit st, input bit kl);
        in_valid = v;
        in_pc    = pc;
        in_ofs   = 2'(ofs);
        in_cnt   = 3'(cnt);
        deq_cnt  = 2'(deq);
        stall    = st;
        kill     = kl;
        for (int i = 0; i < FW; i++) in_insn[i*IL +: IL] = $urandom;
        cycle();
    endtask

    task automatic idle();
        drive(1'b0, '0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_insn  = '0;
        in_pc    = '0;
        in_ofs   = '0;
        in_cnt   = '0;
        deq_cnt  = '0;
        stall    = 1'b0;
        kill     = 1'b0;

        // Reset state
        #3;
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_out_cnt", 64'(out_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_insn", 64'(out_insn), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-operation: 5 entries, then an asynchronous pulse between edges
        drive(1'b1, 32'h1000, 0, 4, 0, 1'b0, 1'b0);
        drive(1'b1, 32'h1010, 0, 1, 0, 1'b0, 1'b0);
        check("fill5_occupancy", 64'(occupancy), 64'd5);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("amid_rst_occupancy", 64'(occupancy), 64'd0);
        check("amid_rst_out_cnt", 64'(out_cnt), 64'd0);
        check("amid_rst_in_ready", 64'(in_ready), 64'd1);
        check("amid_rst_out_insn", 64'(out_insn), 64'd0);
        #1;
        reset = 1'b0;
        q.delete();
        @(posedge clk);
        #1;

        // Partial bundle: slots 1..3 of a bundle at 0x100
        drive(1'b1, 32'h100, 1, 3, 0, 1'b0, 1'b0);
        check("partial_occupancy", 64'(occupancy), 64'd3);
        check("partial_lane0_pc", 64'(out_pc[0 +: AL]), 64'h104);
        check("partial_lane1_pc", 64'(out_pc[AL +: AL]), 64'h108);
        drive(1'b0, '0, 0, 0, 2, 1'b0, 1'b0);
        check("partial_deq_pc", 64'(out_pc[0 +: AL]), 64'h10C);
        check("partial_deq_out_cnt", 64'(out_cnt), 64'd1);
        drive(1'b0, '0, 0, 0, 1, 1'b0, 1'b0);

        // Wrap-around: head = tail = 3 now; push 11 more through to reach 14
        drive(1'b1, 32'h3000, 0, 4, 0, 1'b0, 1'b0);
        drive(1'b1, 32'h3010, 0, 4, 2, 1'b0, 1'b0);
        drive(1'b1, 32'h3020, 0, 3, 2, 1'b0, 1'b0);
        repeat (4) drive(1'b0, '0, 0, 0, 2, 1'b0, 1'b0);
        drive(1'b0, '0, 0, 0, 1, 1'b0, 1'b0);
        check("wrap_empty", 64'(occupancy), 64'd0);
        drive(1'b1, 32'h200, 0, 4, 0, 1'b0, 1'b0);
        check("wrap_pc0", 64'(out_pc[0 +: AL]), 64'h200);
        check("wrap_pc1", 64'(out_pc[AL +: AL]), 64'h204);
        drive(1'b0, '0, 0, 0, 2, 1'b0, 1'b0);
        check("wrap_pc2", 64'(out_pc[0 +: AL]), 64'h208);
        check("wrap_pc3", 64'(out_pc[AL +: AL]), 64'h20C);
        drive(1'b0, '0, 0, 0, 2, 1'b0, 1'b0);

        // Backpressure
        repeat (3) drive(1'b1, 32'h5000, 0, 4, 2, 1'b1, 1'b0);
        check("bp_ready_at_12", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h5100, 0, 1, 2, 1'b1, 1'b0);
        check("bp_occupancy_13", 64'(occupancy), 64'd13);
        check("bp_ready_at_13", 64'(in_ready), 64'd0);
        repeat (2) drive(1'b1, 32'h5200, 0, 4, 2, 1'b1, 1'b0);
        check("bp_hold_occupancy", 64'(occupancy), 64'd13);
        drive(1'b0, '0, 0, 0, 2, 1'b0, 1'b0);
        check("bp_release_ready", 64'(in_ready), 64'd1);

        // Kill collision
        drive(1'b0, '0, 0, 0, 0, 1'b0, 1'b1);
        drive(1'b1, 32'h6000, 0, 4, 0, 1'b0, 1'b0);
        drive(1'b1, 32'h6010, 0, 2, 0, 1'b0, 1'b0);
        check("kill_pre_occupancy", 64'(occupancy), 64'd6);
        drive(1'b1, 32'h6100, 0, 4, 2, 1'b1, 1'b1);
        check("kill_occupancy", 64'(occupancy), 64'd0);
        check("kill_out_cnt", 64'(out_cnt), 64'd0);
        drive(1'b1, 32'h400, 0, 4, 0, 1'b0, 1'b0);
        check("kill_next_pc", 64'(out_pc[0 +: AL]), 64'h400);

        // Clamp and stall
        drive(1'b0, '0, 0, 0, 0, 1'b0, 1'b1);
        drive(1'b1, 32'h700, 2, 1, 0, 1'b0, 1'b0);
        check("clamp_pre", 64'(occupancy), 64'd1);
        drive(1'b0, '0, 0, 0, 2, 1'b0, 1'b0);
        check("clamp_occupancy", 64'(occupancy), 64'd0);
        drive(1'b1, 32'h800, 0, 3, 0, 1'b0, 1'b0);
        drive(1'b0, '0, 0, 0, 2, 1'b1, 1'b0);
        check("stall_occupancy", 64'(occupancy), 64'd3);
        check("stall_lane0_pc", 64'(out_pc[0 +: AL]), 64'h800);
        check("stall_lane1_pc", 64'(out_pc[AL +: AL]), 64'h804);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int ofs;
            ofs = $urandom_range(0, FW - 1);
            drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, ofs,
                  $urandom_range(0, FW - ofs), $urandom_range(0, 3),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
